// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encodings, timestamp width and pointer-width helper for the trace capture unit
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    localparam int TS_W = 16;

    // Smallest r with 2**r >= value; at least 1 so pointers never collapse to zero width
    function automatic int log2_ceil(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port sample buffer, synchronous write and registered read with enable
module trace_ram
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [log2_ceil(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        re,
    input  logic [log2_ceil(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only updates on re, so a stalled consumer sees stable data
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trace_capture_unit.sv
// rtl/trace_capture_unit.sv - circular-buffer debug probe: pre/post-trigger capture then oldest-first dump
// Optional TRACE_TIMESTAMP_EN stores a 16-bit cycle stamp with each sample and exposes it on rd_ts.
module trace_capture_unit
    import trace_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   probe_valid,
    input  logic [NUM_CH*CH_W-1:0] probe_data,
    input  logic                   trig_in,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [NUM_CH*CH_W-1:0] rd_data,
    output logic                   rd_last,
    output logic [1:0]             state,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]        rd_ts,
`endif
    output logic                   trig_seen
);

    localparam int DW = NUM_CH * CH_W;
    localparam int AW = log2_ceil(DEPTH);
    localparam int FW = AW + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int WW = DW + TS_W;
`else
    localparam int WW = DW;
`endif
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
    localparam logic [FW-1:0] FULL      = FW'(DEPTH);

    state_t         cur, nxt;
    logic [AW-1:0]  wptr, rptr, post_cnt;
    logic [FW-1:0]  fill, rem;
    logic           rd_valid_q, trig_seen_q;
    logic           wr_en, rd_re, handshake;
    logic [AW-1:0]  wptr_nxt;
    logic [FW-1:0]  fill_nxt;
    logic [WW-1:0]  ram_wdata, ram_rdata;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    assign ram_wdata = {ts_cnt, probe_data};
    assign rd_ts     = rd_valid_q ? ram_rdata[WW-1 -: TS_W] : '0;
`else
    assign ram_wdata = probe_data;
`endif

    assign handshake = rd_valid_q && rd_ready;
    assign wptr_nxt  = wr_en ? wptr + AW'(1) : wptr;
    assign fill_nxt  = (wr_en && fill != FULL) ? fill + FW'(1) : fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= ST_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt   = cur;
        wr_en = 1'b0;
        rd_re = 1'b0;
        case (cur)
            ST_IDLE: begin
                if (arm) begin
                    nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                wr_en = probe_valid;
                if (trig_in) begin
                    nxt = (POST_TRIG == 0) ? ST_DUMP : ST_POST;
                end
            end
            ST_POST: begin
                wr_en = probe_valid;
                if (probe_valid && post_cnt == AW'(1)) begin
                    nxt = ST_DUMP;
                end
            end
            ST_DUMP: begin
                // Prefetch the next entry whenever the output slot is empty or being consumed
                rd_re = (rem != '0) && (!rd_valid_q || (rd_ready && rem != FW'(1)));
                if (rem == '0 || (handshake && rem == FW'(1))) begin
                    nxt = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            fill        <= '0;
            rem         <= '0;
            post_cnt    <= '0;
            rd_valid_q  <= 1'b0;
            trig_seen_q <= 1'b0;
        end else begin
            case (cur)
                ST_IDLE: begin
                    if (arm) begin
                        wptr <= '0;
                        fill <= '0;
                    end
                end
                ST_PRE, ST_POST: begin
                    wptr <= wptr_nxt;
                    fill <= fill_nxt;
                    if (cur == ST_PRE && trig_in) begin
                        trig_seen_q <= 1'b1;
                        post_cnt    <= POST_LOAD;
                    end else if (cur == ST_POST && wr_en) begin
                        post_cnt <= post_cnt - AW'(1);
                    end
                    // Oldest entry is fill slots behind the write pointer; a full buffer wraps to wptr itself
                    if (nxt == ST_DUMP) begin
                        rptr <= wptr_nxt - fill_nxt[AW-1:0];
                        rem  <= fill_nxt;
                    end
                end
                ST_DUMP: begin
                    if (rd_re) begin
                        rptr       <= rptr + AW'(1);
                        rd_valid_q <= 1'b1;
                    end else if (handshake) begin
                        rd_valid_q <= 1'b0;
                    end
                    if (handshake) begin
                        rem <= rem - FW'(1);
                    end
                    if (nxt == ST_IDLE) begin
                        trig_seen_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (ram_wdata),
        .re    (rd_re),
        .raddr (rptr),
        .rdata (ram_rdata)
    );

    // Gate the unreset RAM output so the stream reads zero whenever nothing is presented
    assign rd_data   = rd_valid_q ? ram_rdata[DW-1:0] : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_valid_q && (rem == FW'(1));
    assign state     = cur;
    assign trig_seen = trig_seen_q;

endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
Parametrised, synthesisable debug probe for the KGP-RISC core. It generalises the four single-bit debug taps (instruction, ALU result, jump offset, PC) into NUM_CH full-width channels. Samples are captured into a circular buffer until a trigger fires, then a fixed post-trigger window is captured, then the buffer is dumped oldest-first over a valid/ready stream. It sits beside the core top level and observes probe buses driven by the datapath.

Parameters:
NUM_CH, 4, number of probe channels
CH_W, 32, width of each channel in bits
DEPTH, 16, buffer entries; power of two, at least 2
POST_TRIG, 8, samples captured after the trigger sample; range 0..DEPTH-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
arm  in  1  single-cycle pulse; starts a capture
probe_valid  in  1  current probe_data is a sample (for example, instruction retire)
probe_data  in  NUM_CH*CH_W  channel k occupies bits [k*CH_W +: CH_W]
trig_in  in  1  trigger event
rd_ready  in  1  consumer accepts rd_data
rd_valid  out  1  rd_data holds a buffered sample
rd_data  out  NUM_CH*CH_W  dumped sample
rd_last  out  1  marks the final dumped sample
state  out  2  FSM state: 0 IDLE, 1 PRE, 2 POST, 3 DUMP
trig_seen  out  1  high from trigger acceptance until the dump completes

Behaviour:
- Reset, asynchronous:
  - All outputs are 0; state is IDLE.
  - Write pointer, fill count and post counter are 0.
  - Buffer contents are don't-care.
  - Reset asserted in any state aborts the operation immediately.
- IDLE:
  - arm moves to PRE next cycle and clears wptr and fill.
  - probe_valid, trig_in and rd_ready are ignored.
- PRE:
  - Each probe_valid writes probe_data at wptr.
  - wptr increments modulo DEPTH. fill increments and saturates at DEPTH.
  - On trig_in, trig_seen is set and post counter loads POST_TRIG.
  - A sample written in the same cycle as trig_in is the trigger sample and belongs to the pre-window.
  - If POST_TRIG=0, go to DUMP; otherwise go to POST.
- POST:
  - Each probe_valid writes as in PRE and decrements the post counter.
  - The write that takes the counter to 0 moves the FSM to DUMP.
  - trig_in is ignored.
- DUMP:
  - Read pointer starts at (wptr - fill) mod DEPTH, the oldest entry.
  - Buffer read is synchronous, so rd_valid rises one cycle after entering DUMP.
  - Each handshake (rd_valid and rd_ready) advances the read pointer modulo DEPTH and presents the next entry the following cycle, giving back-to-back throughput of 1 per cycle.
  - While rd_valid=1 and rd_ready=0, rd_data and rd_last are held stable.
  - Exactly fill entries are emitted; rd_last=1 only with the final one.
  - After the final handshake: rd_valid=0, trig_seen=0, return to IDLE.
  - If fill=0 (trigger with no samples, POST_TRIG=0), return to IDLE after one cycle; rd_valid never asserts.
- arm is ignored outside IDLE. probe_valid is ignored in IDLE and DUMP.
- Wrap-around: once more than DEPTH samples are written, the oldest entries are overwritten. POST_TRIG<=DEPTH-1 guarantees the trigger sample survives.

Optional Feature:
TRACE_TIMESTAMP_EN:
- Defined:
  - Adds a 16-bit free-running cycle counter (reset 0, wraps at 65535).
  - The counter value is stored with every sample.
  - Adds output rd_ts [15:0], aligned and held exactly like rd_data.
- Undefined: no counter, no rd_ts port, buffer width is NUM_CH*CH_W.

Decomposition:
- Shared header/package trace_pkg:
  - state encodings ST_IDLE=2'd0, ST_PRE=2'd1, ST_POST=2'd2, ST_DUMP=2'd3.
  - TS_W=16.
  - log2 helper for pointer widths.
- One sub-module, trace_ram:
  - simple dual-port, DEPTH x word width.
  - one synchronous write port, one synchronous read port with read enable.
  - no reset on the array.

Test Plan (NUM_CH=4, CH_W=32, DEPTH=16, POST_TRIG=8 unless stated):
1. Reset mid-operation: arm, write 3 samples, pulse rst -> state=0, rd_valid=0, trig_seen=0 immediately. A new arm then captures from an empty buffer.
2. Wrap-around: arm, then samples with value k for k=0..19. trig_in with sample 10 -> samples 11..18 captured, state=3. Dump emits 16 entries 3..18 in order, rd_last on 18. Sample 19 is ignored.
3. Partial fill: arm, samples 0..2, trig_in without probe_valid, samples 3..10 -> dump emits 11 entries 0..10, rd_last on 10.
4. Backpressure: during test 2's dump, hold rd_ready=0 for 5 cycles at entry 7 -> rd_data stays 7 throughout. Order and count are unchanged, no loss or duplication.
5. Ignored events: trig_in in IDLE and arm during DUMP -> no state change; the dump completes normally.
6. Empty capture (POST_TRIG=0 instance): arm, trig_in with no probe_valid -> DUMP for 1 cycle then IDLE, rd_valid never high. With TRACE_TIMESTAMP_EN, rd_ts equals the cycle count at each write.
